// File: rtl/mem_access_unit_pkg.sv
// Shared size codes, FSM state encoding and request bundle for the memory access unit.
// Both the control unit and byte_enabler import these so the encodings cannot drift apart.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [1:0]  off;
    logic [3:0]  be;
    logic        sext;
    logic [31:0] wdata;
  } acc_t;

  // 2'b11 falls into the word rule.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/halfword out of a read word and zero- or sign-extends it.
// Purely combinational so a cache fill path can share it.
module load_extender
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sext,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: result = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{sext & half_sel[15]}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: stalls the pipeline while a single access is on the
// valid/ready bus, aborting on misalignment or when the bus stays silent too long.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  input  logic          sext,
  output logic          stall,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ready,
  input  logic          bus_rvalid,
  input  logic [31:0]   bus_rdata
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  acc_t             acc_q, acc_d;
  logic [AW-3:0]    waddr_q, waddr_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [NUM_LANES-1:0][LANE_W-1:0] rep_wdata;
  logic [31:0]                      ext_word;
  logic                             timeout_hit;

  // Store data is replicated per lane at request time so the bus side is a plain register.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_comb begin
      case (size)
        SZ_BYTE: rep_wdata[i] = wdata[7:0];
        SZ_HALF: rep_wdata[i] = wdata[(i%2)*LANE_W +: LANE_W];
        default: rep_wdata[i] = wdata[i*LANE_W +: LANE_W];
      endcase
    end
  end

  load_extender u_ext (
    .size   (acc_q.size),
    .offset (acc_q.off),
    .sext   (acc_q.sext),
    .word   (bus_rdata),
    .result (ext_word)
  );

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      waddr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      waddr_q <= waddr_d;
      rdata_q <= rdata_d;
    end
  end

  // Completion is tested before the timeout so a response on the last cycle still wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    waddr_d = waddr_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (is_aligned(size, addr[1:0])) begin
            state_d = ST_REQ;
            cnt_d   = '0;
            acc_d   = '{we: we, size: size, off: addr[1:0], be: be, sext: sext,
                        wdata: rep_wdata};
            waddr_d = addr[AW-1:2];
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_ready)        state_d = acc_q.we ? ST_DONE : ST_WAIT;
        else if (timeout_hit) state_d = ST_ERR;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid) begin
          rdata_d = ext_word;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    case (state_q)
      ST_IDLE: stall = req;
      ST_REQ: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = acc_q.we;
        bus_addr  = {waddr_q, 2'b00};
        bus_be    = acc_q.be;
        bus_wdata = acc_q.wdata;
      end
      ST_WAIT: stall = 1'b1;
      ST_DONE: done  = 1'b1;
      ST_ERR:  err   = 1'b1;
      default: ;
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT=4: stores, extended loads,
// misalignment, bus timeout, completion-vs-timeout race and mid-access reset.
module tb_mem_access_unit;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, we, sext;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic          stall, done, err;
  logic [31:0]   rdata;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [31:0]   bus_wdata;
  logic          bus_ready, bus_rvalid;
  logic [31:0]   bus_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .size       (size),
    .addr       (addr),
    .wdata      (wdata),
    .be         (be),
    .sext       (sext),
    .stall      (stall),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, want);
  endtask

  // Inputs change 2 time units after the rising edge; checks run after a further #1.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic sx);
    req = 1'b1; we = w; size = sz; addr = a; wdata = d; be = b; sext = sx;
  endtask

  // Load through REQ (bus_ready on first cycle) and WAIT (rvalid on first cycle).
  task automatic do_load(input string tag, input logic [1:0] sz, input logic [31:0] a,
                         input logic sx, input logic [31:0] rd, input logic [31:0] want);
    tick(); issue(1'b0, sz, a, 32'h0, 4'hF, sx);
    tick(); req = 1'b0; bus_ready = 1'b1;
    #1 chk({tag, "_busreq"}, 32'(bus_req), 32'd1);
    tick(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd;
    #1 chk({tag, "_wait_stall"}, 32'(stall), 32'd1);
    tick(); bus_rvalid = 1'b0;
    #1 chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_rdata"}, rdata, want);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    be = '0; sext = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busreq", 32'(bus_req), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busaddr", bus_addr, 32'h0);
    chk("rst_buswdata", bus_wdata, 32'h0);
    chk("rst_flags", {28'h0, done, err, bus_we, |bus_be}, 32'h0);
    tick(); reset = 1'b0;

    // Store byte, bus_ready on the second REQ cycle.
    tick(); issue(1'b1, 2'b01, 32'h1003, 32'h0000_00AB, 4'b1000, 1'b0);
    #1 chk("sb_idle_stall", 32'(stall), 32'd1);
    chk("sb_idle_busreq", 32'(bus_req), 32'd0);
    tick(); req = 1'b0; wdata = 32'h0;
    #1 chk("sb_busreq", 32'(bus_req), 32'd1);
    chk("sb_busaddr", bus_addr, 32'h1000);
    chk("sb_busbe", 32'(bus_be), 32'h8);
    chk("sb_buswdata", bus_wdata, 32'hABAB_ABAB);
    chk("sb_buswe", 32'(bus_we), 32'd1);
    tick(); bus_ready = 1'b1;
    #1 chk("sb_req2_stall", 32'(stall), 32'd1);
    chk("sb_req2_addr", bus_addr, 32'h1000);
    tick(); bus_ready = 1'b0;
    #1 chk("sb_done", 32'(done), 32'd1);
    chk("sb_done_stall", 32'(stall), 32'd0);
    chk("sb_done_busreq", 32'(bus_req), 32'd0);
    tick();
    #1 chk("sb_idle_after", 32'(done), 32'd0);

    // Halfword stores replicate the low half; word store passes through.
    tick(); issue(1'b1, 2'b10, 32'h1102, 32'hDEAD_BEEF, 4'b1100, 1'b0);
    tick(); req = 1'b0; bus_ready = 1'b1;
    #1 chk("sh_buswdata", bus_wdata, 32'hBEEF_BEEF);
    tick(); bus_ready = 1'b0;
    #1 chk("sh_done", 32'(done), 32'd1);

    do_load("lh_sext", 2'b10, 32'h2002, 1'b1, 32'h8001_1234, 32'hFFFF_8001);
    do_load("lh_zext", 2'b10, 32'h2002, 1'b0, 32'h8001_1234, 32'h0000_8001);
    do_load("lh_lo",   2'b10, 32'h2000, 1'b1, 32'h8001_1234, 32'h0000_1234);
    do_load("lb_sext", 2'b01, 32'h2001, 1'b1, 32'h1234_80FF, 32'hFFFF_FF80);
    do_load("lb_zext", 2'b01, 32'h2003, 1'b0, 32'hC234_80FF, 32'h0000_00C2);
    do_load("lw",      2'b00, 32'h2004, 1'b1, 32'h8765_4321, 32'h8765_4321);

    // Misaligned word: error next cycle, bus never requested, rdata held.
    tick(); issue(1'b0, 2'b00, 32'h3001, 32'h0, 4'hF, 1'b0);
    #1 chk("mis_stall", 32'(stall), 32'd1);
    chk("mis_busreq0", 32'(bus_req), 32'd0);
    tick(); req = 1'b0;
    #1 chk("mis_err", 32'(err), 32'd1);
    chk("mis_busreq1", 32'(bus_req), 32'd0);
    chk("mis_rdata", rdata, 32'h8765_4321);
    chk("mis_stall_err", 32'(stall), 32'd0);
    tick();
    #1 chk("mis_err_clr", 32'(err), 32'd0);

    // Misaligned halfword also aborts.
    tick(); issue(1'b1, 2'b10, 32'h3003, 32'h0, 4'hF, 1'b0);
    tick(); req = 1'b0;
    #1 chk("mish_err", 32'(err), 32'd1);

    // Load timeout: bus_ready then no rvalid; err after 4 cycles in REQ+WAIT.
    tick(); issue(1'b0, 2'b00, 32'h4000, 32'h0, 4'hF, 1'b0);
    tick(); req = 1'b0; bus_ready = 1'b1;
    #1 chk("to_busreq", 32'(bus_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); bus_ready = 1'b0;
      #1 chk($sformatf("to_wait%0d", i), {30'h0, done, err}, 32'h0);
    end
    tick();
    #1 chk("to_err", 32'(err), 32'd1);
    chk("to_nodone", 32'(done), 32'd0);
    chk("to_busreq_low", 32'(bus_req), 32'd0);
    chk("to_rdata", rdata, 32'h8765_4321);

    // Store stuck in REQ also times out after 4 cycles.
    tick(); issue(1'b1, 2'b00, 32'h4100, 32'h5555_AAAA, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); req = 1'b0;
      #1 chk($sformatf("tor_req%0d", i), 32'(bus_req), 32'd1);
    end
    tick();
    #1 chk("tor_err", 32'(err), 32'd1);

    // rvalid on the final count cycle: completion beats timeout.
    tick(); issue(1'b0, 2'b00, 32'h5000, 32'h0, 4'hF, 1'b0);
    tick(); req = 1'b0; bus_ready = 1'b1;
    tick(); bus_ready = 1'b0;
    tick();
    tick(); bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick(); bus_rvalid = 1'b0;
    #1 chk("race_done", 32'(done), 32'd1);
    chk("race_noerr", 32'(err), 32'd0);
    chk("race_rdata", rdata, 32'hCAFE_F00D);
    tick();
    #1 chk("race_after", {30'h0, done, err}, 32'h0);

    // Reset in WAIT: outputs clear immediately, next request completes.
    tick(); issue(1'b0, 2'b00, 32'h6000, 32'h0, 4'hF, 1'b0);
    tick(); req = 1'b0; bus_ready = 1'b1;
    tick(); bus_ready = 1'b0;
    #1 chk("rw_stall_pre", 32'(stall), 32'd1);
    reset = 1'b1;
    #1 chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_busreq", 32'(bus_req), 32'd0);
    chk("rw_rdata", rdata, 32'h0);
    chk("rw_flags", {30'h0, done, err}, 32'h0);
    tick(); reset = 1'b0;
    tick(); issue(1'b1, 2'b00, 32'h6004, 32'h1122_3344, 4'hF, 1'b0);
    tick(); req = 1'b0; bus_ready = 1'b1;
    #1 chk("rw_st_addr", bus_addr, 32'h6004);
    chk("rw_st_wdata", bus_wdata, 32'h1122_3344);
    tick(); bus_ready = 1'b0;
    #1 chk("rw_st_done", 32'(done), 32'd1);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
